// File: rtl/lfsr_count_checker.sv
// Reference model and checker for a 4-bit dynamic count-to XNOR LFSR counter:
// tracks the expected state, flags count/tercnt disagreements, reports step and period.
module lfsr_count_checker #(
  parameter int                unsigned width = 4,
  parameter logic [width-1:0]  TAPS  = 4'b1100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] data,
  input  logic [width-1:0] count_to,
  input  logic             load,
  input  logic             cen,
  input  logic [width-1:0] count,
  input  logic             tercnt,
  output logic [width-1:0] step,
  output logic [width-1:0] period,
  output logic             period_vld,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [7:0]       err_cnt,
  output logic             in_sync
);

  typedef enum logic {TRACK, FAULT} state_t;

  state_t             state_q, state_d;
  logic [width-1:0]   m_q, m_d;
  logic [width-1:0]   step_q, step_d;
  logic [width-1:0]   period_q, period_d;
  logic               period_vld_q, period_vld_d;
  logic               mismatch_q, mismatch_d;
  logic               err_sticky_q, err_sticky_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               exp_ter;
  logic               wrap;
  logic               fail;
  logic               fb;

  assign exp_ter = (m_q == count_to);
  // A load in the same cycle as the terminal state takes priority over the wrap.
  assign wrap    = load && cen && exp_ter;
  assign fb      = ~^(m_q & TAPS);
  assign fail    = (state_q == TRACK) && ((count != m_q) || (tercnt != exp_ter));

  always_comb begin
    m_d          = m_q;
    step_d       = step_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    if (!load) begin
      m_d    = data;
      step_d = '0;
    end else if (wrap) begin
      m_d          = '0;
      step_d       = '0;
      period_d     = step_q + 1'b1;
      period_vld_d = 1'b1;
    end else if (cen) begin
      m_d    = {m_q[width-2:0], fb};
      step_d = step_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    mismatch_d   = fail;
    err_sticky_d = err_sticky_q | fail;
    err_cnt_d    = err_cnt_q;
    if (fail && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    case (state_q)
      TRACK: if (fail)  state_d = FAULT;
      FAULT: if (!load) state_d = TRACK;
      default:          state_d = TRACK;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= TRACK;
      m_q          <= '0;
      step_q       <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      step_q       <= step_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign step       = step_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;
  assign in_sync    = (state_q == TRACK);

endmodule

// File: tb/tb_lfsr_count_checker.sv
// Directed-vector bench for lfsr_count_checker; expected outputs are queued by the
// driver and popped/compared by an independent monitor on the falling edge.
module tb_lfsr_count_checker;

  typedef struct packed {
    logic [3:0] step;
    logic [3:0] period;
    logic       pvld;
    logic       mism;
    logic       sticky;
    logic [7:0] errc;
    logic       insync;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] data = 4'h0;
  logic [3:0] count_to = 4'hF;
  logic       load = 1'b1;
  logic       cen = 1'b0;
  logic [3:0] count = 4'h0;
  logic       tercnt = 1'b0;
  logic [3:0] step;
  logic [3:0] period;
  logic       period_vld;
  logic       mismatch;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic       in_sync;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  lfsr_count_checker #(.width(4), .TAPS(4'b1100)) dut (
    .clk(clk), .reset(reset), .data(data), .count_to(count_to), .load(load),
    .cen(cen), .count(count), .tercnt(tercnt), .step(step), .period(period),
    .period_vld(period_vld), .mismatch(mismatch), .err_sticky(err_sticky),
    .err_cnt(err_cnt), .in_sync(in_sync)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] s, input logic [3:0] p, input logic pv,
                              input logic mm, input logic st, input logic [7:0] ec,
                              input logic is);
    exp_t e;
    e.step = s; e.period = p; e.pvld = pv; e.mism = mm;
    e.sticky = st; e.errc = ec; e.insync = is;
    return e;
  endfunction

  function automatic exp_t actual();
    return mk(step, period, period_vld, mismatch, err_sticky, err_cnt, in_sync);
  endfunction

  task automatic compare(input exp_t e, input string nm);
    exp_t a;
    a = actual();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got step=%h period=%h pvld=%b mism=%b sticky=%b err=%0d sync=%b, want step=%h period=%h pvld=%b mism=%b sticky=%b err=%0d sync=%b",
               nm, a.step, a.period, a.pvld, a.mism, a.sticky, a.errc, a.insync,
               e.step, e.period, e.pvld, e.mism, e.sticky, e.errc, e.insync);
    end else begin
      $display("ok   %s: step=%h period=%h pvld=%b mism=%b err=%0d sync=%b",
               nm, a.step, a.period, a.pvld, a.mism, a.errc, a.insync);
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic cyc(input logic ld, input logic ce, input logic [3:0] dat,
                     input logic [3:0] cto, input logic [3:0] cnt, input logic tc,
                     input exp_t e, input string nm);
    load = ld; cen = ce; data = dat; count_to = cto; count = cnt; tercnt = tc;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        compare(e, nm);
      end
    end
  end

  initial begin : driver
    logic [3:0] seq_a [8];
    logic [3:0] seq_b [6];
    logic [7:0] ec;
    seq_a = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6};
    seq_b = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'h0};

    #2;
    compare(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "reset_values");
    @(negedge clk); #1;
    reset = 1'b1;

    // Free run with count_to=F: step counts 1..8 after each enabled edge.
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 1'b1, 4'h0, 4'hF, seq_a[i], 1'b0,
          mk(4'(i + 1), 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), $sformatf("run_ctF_%0d", i));

    // Mid-count asynchronous reset: outputs clear before any clock edge.
    #2;
    reset = 1'b0;
    #1;
    compare(mk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "async_reset_midcount");
    @(negedge clk); #1;
    reset = 1'b1;

    // count_to=E: terminal at E (step 4), wrap to 0 reports period 5 once.
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 1'b1, 4'h0, 4'hE, seq_b[i], (seq_b[i] == 4'hE) && (i == 4),
          (i == 4) ? mk(4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1)
                   : mk((i < 4) ? 4'(i + 1) : 4'h1, (i < 4) ? 4'h0 : 4'h5, 1'b0, 1'b0,
                        1'b0, 8'd0, 1'b1),
          $sformatf("run_ctE_%0d", i));

    // Load 3, then three enables: 3,7,E,D with step 0..3.
    cyc(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "load3");
    cyc(1'b1, 1'b1, 4'h0, 4'hF, 4'h3, 1'b0, mk(4'h1, 4'h5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "load3_s1");
    cyc(1'b1, 1'b1, 4'h0, 4'hF, 4'h7, 1'b0, mk(4'h2, 4'h5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "load3_s2");
    cyc(1'b1, 1'b1, 4'h0, 4'hF, 4'hE, 1'b0, mk(4'h3, 4'h5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "load3_s3");

    // Forced single error: count=5 where 7 is expected.
    cyc(1'b0, 1'b1, 4'h3, 4'hF, 4'hD, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "err_reload");
    cyc(1'b1, 1'b1, 4'h0, 4'hF, 4'h3, 1'b0, mk(4'h1, 4'h5, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1), "err_pre");
    cyc(1'b1, 1'b1, 4'h0, 4'hF, 4'h5, 1'b0, mk(4'h2, 4'h5, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0), "err_hit");
    cyc(1'b1, 1'b1, 4'h0, 4'hF, 4'hE, 1'b0, mk(4'h3, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0), "err_fault1");
    cyc(1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, mk(4'h3, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0), "err_fault_nocnt");
    cyc(1'b0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1), "err_resync");
    cyc(1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1), "err_tracking");

    // Load coinciding with a terminal wrap: load wins, no period pulse.
    cyc(1'b1, 1'b1, 4'h0, 4'h1, 4'h0, 1'b0, mk(4'h1, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1), "lw_pre");
    cyc(1'b0, 1'b1, 4'h7, 4'h1, 4'h1, 1'b1, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1), "lw_collide");
    cyc(1'b1, 1'b0, 4'h0, 4'h1, 4'h7, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1), "lw_model7");

    // 300 forced failures separated by reloads: err_cnt saturates at 255.
    for (int k = 1; k <= 300; k++) begin
      ec = (k + 1 > 255) ? 8'd255 : 8'(k + 1);
      cyc(1'b1, 1'b0, 4'h0, 4'h1, 4'h0, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b1, 1'b1, ec, 1'b0),
          $sformatf("sat_fail_%0d", k));
      cyc(1'b0, 1'b0, 4'h7, 4'h1, 4'h0, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b1, ec, 1'b1),
          $sformatf("sat_load_%0d", k));
    end

    // All-ones lock-up: model stays at F and the compare still passes.
    cyc(1'b0, 1'b0, 4'hF, 4'h1, 4'h7, 1'b0, mk(4'h0, 4'h5, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1), "lock_load");
    cyc(1'b1, 1'b1, 4'h0, 4'h1, 4'hF, 1'b0, mk(4'h1, 4'h5, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1), "lock_s1");
    cyc(1'b1, 1'b1, 4'h0, 4'h1, 4'hF, 1'b0, mk(4'h2, 4'h5, 1'b0, 1'b0, 1'b1, 8'd255, 1'b1), "lock_s2");

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_count_checker.md
# lfsr_count_checker

Self-checking decoder that sits on the output side of the 4-bit dynamic count-to LFSR counter in the LFSR test harness. It observes the same stimulus the counter receives (`data`, `count_to`, `load`, `cen`) and runs a cycle-accurate reference model of the counter. It compares the counter's `count` and `tercnt` against that model and decodes the pseudo-random state into a binary step index. It reports the measured sequence period and latches errors, so the harness becomes self-checking instead of relying on waveform inspection.

## Interface
- `width`, 4: counter width; all data, count, step and period buses use this width.
- `TAPS`, 4'b1100: feedback tap mask. Must equal the configuration of the observed counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `data` input width: parallel load value presented to the counter.
- `count_to` input width: terminal state presented to the counter.
- `load` input 1: active-low synchronous load, same as the counter.
- `cen` input 1: active-high count enable.
- `count` input width: counter state under check.
- `tercnt` input 1: counter terminal flag under check.
- `step` output width: number of enabled advances since the last reset, load or terminal wrap.
- `period` output width: number of states in the last completed terminal cycle.
- `period_vld` output 1: one-cycle pulse when `period` updates.
- `mismatch` output 1: registered, one cycle after any compare failure.
- `err_sticky` output 1: latched error; cleared only by reset.
- `err_cnt` output 8: saturating count of failing cycles.
- `in_sync` output 1: high in state TRACK.

## Operation
- Model register `m`: reset value 0.
  - Priority 1: `load`=0 → `m`=`data`.
  - Priority 2: `cen`=1 and `m`==`count_to` → `m`=0 (terminal wrap).
  - Priority 3: `cen`=1 → `m`={`m`[width-2:0], ~^(`m` & `TAPS`)}.
  - Otherwise `m` holds.
- Expected terminal flag: `m`==`count_to`, combinational.
- Compare each cycle: fail = (`count`≠`m`) or (`tercnt`≠(`m`==`count_to`)).
  - Compares run only in TRACK.
- FSM states:
  - TRACK: reset state. A fail moves to FAULT.
  - FAULT: model keeps running. No further `err_cnt` increments. `load`=0 moves back to TRACK on the next cycle, with the model reloaded from `data`.
- `step`:
  - Cleared to 0 on load or terminal wrap.
  - Increments on each other `cen` advance.
  - Wraps modulo 2^width.
- `period`:
  - On a terminal wrap, `period` = `step`+1 and `period_vld` pulses.
  - The first wrap after reset or load reports a partial cycle. It is still reported.
- `err_cnt` saturates at 255.
- Simultaneous `load`=0 and a terminal condition: load wins. No `period_vld`.
- All-ones is the XNOR lock-up state. If loaded, the model stays at all-ones and does not flag the lock-up itself. The compare still applies.

## Timing
- Reset (asynchronous, `reset`=0) values:
  - `m`=0, `step`=0, `period`=0.
  - `period_vld`=0, `mismatch`=0, `err_sticky`=0, `err_cnt`=0.
  - `in_sync`=1, state TRACK.
- Model updates on the same edge as the counter, so `m` and `count` are aligned with zero skew.
- Compare is combinational on cycle N. `mismatch`, `err_sticky` and `err_cnt` update on the edge ending cycle N, so they are visible in N+1.
- `period_vld` is asserted in the cycle after the wrapping edge.
- Reset asserted mid-sequence clears everything immediately. Outputs are valid from the first edge after release.

## Test plan
- Reset, `load`=1, `cen`=1, `count_to`=4'hF, counter correct:
  - `count` sequence 0,1,3,7,E,D,B,6.
  - `step` 0..7, `mismatch`=0 throughout, `in_sync`=1.
- `count_to`=4'hE from reset:
  - `tercnt` high at `count`=E (`step`=4).
  - Next state 0, `period`=5, `period_vld` pulses once.
- `load`=0 with `data`=4'h3, then 3 enables:
  - Model follows 3,7,E,D.
  - `step` restarts at 0 and reaches 3.
- Force `count`=4'h5 for one cycle where expected is 7:
  - `mismatch`=1 for one cycle, `err_sticky`=1, `err_cnt`=1.
  - `in_sync`=0 until the next `load`=0, then 1.
- `load`=0 on the same cycle as a terminal wrap (`m`==`count_to`, `cen`=1):
  - `m`=`data`, no `period_vld`.
- Drive 300 forced failures with a `load` pulse between each:
  - `err_cnt` stops at 255.
- Assert `reset` mid-count:
  - All outputs return to reset values asynchronously, before the next edge.
